// File: rtl/vram_rect_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : vram_rect_writer_if
//  Purpose  : Bundles the drawing-command handshake and the VRAM pixel write
//             port of the rectangle writer.
//  Signals  : cmd_valid/cmd_ready  - command handshake
//             cmd_op/x/y/w/h/color - command fields (op 1 = full-screen clear)
//             write_addr/wdata/write_en - one pixel write per clock
//             busy                 - engine executing a command
//  Modports : master - drawing engine side (drives ready, write port, busy)
//             slave  - command source / VRAM side
//  Revision : 1.0  initial release
// ============================================================================
interface vram_rect_writer_if #(
  parameter int ADDR_W = 20
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [7:0]        cmd_x;
  logic [6:0]        cmd_y;
  logic [7:0]        cmd_w;
  logic [6:0]        cmd_h;
  logic              cmd_color;
  logic [ADDR_W-1:0] write_addr;
  logic              wdata;
  logic              write_en;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, write_addr, wdata, write_en, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, write_addr, wdata, write_en, busy
  );

endinterface
`default_nettype wire

// File: rtl/vram_rect_writer.sv
`default_nettype none
// ============================================================================
//  Module   : vram_rect_writer
//  Purpose  : Fills clipped rectangles (or the whole screen) of the 1-bit
//             WIDTH x HEIGHT framebuffer, one pixel write per clock,
//             row-major order.
//  Ports    : clk   - system clock (shared with the VRAM write port)
//             reset - asynchronous, active-high reset
//             bus   - vram_rect_writer_if.master (command handshake in,
//                     VRAM write port and busy out)
//  Revision : 1.0  initial release
// ============================================================================
module vram_rect_writer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 20
) (
  input  logic clk,
  input  logic reset,
  vram_rect_writer_if.master bus
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_setup = 2'd1;
  localparam logic [1:0] c_st_fill  = 2'd2;

  localparam logic [8:0]        c_width9  = 9'(WIDTH);
  localparam logic [7:0]        c_height8 = 8'(HEIGHT);
  localparam logic [ADDR_W-1:0] c_width_a = ADDR_W'(WIDTH);

  // FSM and captured command
  logic [1:0]        state_q, state_d;
  logic              op_q, op_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic [7:0]        w_q, w_d;
  logic [6:0]        h_q, h_d;
  logic              color_q, color_d;

  // Clipped bounds and raster cursor (cursor tracks the pixel on the port)
  logic [7:0]        xs_q, xs_d;
  logic [8:0]        xe_q, xe_d;
  logic [7:0]        ye_q, ye_d;
  logic [7:0]        cx_q, cx_d;
  logic [6:0]        cy_q, cy_d;
  logic [ADDR_W-1:0] rowbase_q, rowbase_d;

  // Registered VRAM write port
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic              wdata_q, wdata_d;

  // Setup-phase bound computation from the captured fields
  logic [8:0]        x_end_raw;
  logic [7:0]        y_end_raw;
  logic [7:0]        setup_xs;
  logic [6:0]        setup_ys;
  logic [8:0]        setup_xe;
  logic [7:0]        setup_ye;
  logic              setup_empty;
  logic [ADDR_W-1:0] setup_rowbase;

  // x+w is 9 bits and y+h is 8 bits wide, so the sums never wrap
  assign x_end_raw = {1'b0, x_q} + {1'b0, w_q};
  assign y_end_raw = {1'b0, y_q} + {1'b0, h_q};

  assign setup_xs = op_q ? 8'd0 : x_q;
  assign setup_ys = op_q ? 7'd0 : y_q;
  assign setup_xe = op_q ? c_width9  : ((x_end_raw > c_width9)  ? c_width9  : x_end_raw);
  assign setup_ye = op_q ? c_height8 : ((y_end_raw > c_height8) ? c_height8 : y_end_raw);

  // A clear is never empty; a rectangle is empty if zero-sized or fully off-screen
  assign setup_empty = !op_q && ((w_q == 8'd0) || (h_q == 7'd0) ||
                                 ({1'b0, x_q} >= c_width9) ||
                                 ({1'b0, y_q} >= c_height8));

  // Row base y*WIDTH: for the native 160-wide screen this is y*128 + y*32
  generate
    if (WIDTH == 160) begin : g_rowbase_shift
      assign setup_rowbase = (ADDR_W'(setup_ys) << 7) + (ADDR_W'(setup_ys) << 5);
    end else begin : g_rowbase_const
      assign setup_rowbase = ADDR_W'(setup_ys) * c_width_a;
    end
  endgenerate

  // Fill-phase end-of-row / end-of-rectangle detection
  logic row_last;
  logic rect_last;

  assign row_last  = ({1'b0, cx_q} == (xe_q - 9'd1));
  assign rect_last = row_last && ({1'b0, cy_q} == (ye_q - 8'd1));

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    h_d          = h_q;
    color_d      = color_q;
    xs_d         = xs_q;
    xe_d         = xe_q;
    ye_d         = ye_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    rowbase_d    = rowbase_q;
    write_en_d   = write_en_q;
    write_addr_d = write_addr_q;
    wdata_d      = wdata_q;

    case (state_q)
      c_st_idle: begin
        write_en_d = 1'b0;
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          x_d     = bus.cmd_x;
          y_d     = bus.cmd_y;
          w_d     = bus.cmd_w;
          h_d     = bus.cmd_h;
          color_d = bus.cmd_color;
          state_d = c_st_setup;
        end
      end

      c_st_setup: begin
        xs_d      = setup_xs;
        xe_d      = setup_xe;
        ye_d      = setup_ye;
        cx_d      = setup_xs;
        cy_d      = setup_ys;
        rowbase_d = setup_rowbase;
        wdata_d   = color_q;
        // The first pixel is loaded onto the port here so writes start
        // the cycle right after SETUP.
        write_addr_d = setup_rowbase + ADDR_W'(setup_xs);
        if (setup_empty) begin
          write_en_d = 1'b0;
          state_d    = c_st_idle;
        end else begin
          write_en_d = 1'b1;
          state_d    = c_st_fill;
        end
      end

      c_st_fill: begin
        if (rect_last) begin
          write_en_d = 1'b0;
          state_d    = c_st_idle;
        end else if (row_last) begin
          cx_d         = xs_q;
          cy_d         = cy_q + 7'd1;
          rowbase_d    = rowbase_q + c_width_a;
          write_addr_d = rowbase_q + c_width_a + ADDR_W'(xs_q);
        end else begin
          cx_d         = cx_q + 8'd1;
          write_addr_d = write_addr_q + ADDR_W'(1);
        end
      end

      default: begin
        write_en_d = 1'b0;
        state_d    = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= c_st_idle;
      op_q         <= 1'b0;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      w_q          <= 8'd0;
      h_q          <= 7'd0;
      color_q      <= 1'b0;
      xs_q         <= 8'd0;
      xe_q         <= 9'd0;
      ye_q         <= 8'd0;
      cx_q         <= 8'd0;
      cy_q         <= 7'd0;
      rowbase_q    <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      wdata_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      color_q      <= color_d;
      xs_q         <= xs_d;
      xe_q         <= xe_d;
      ye_q         <= ye_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      rowbase_q    <= rowbase_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.cmd_ready  = (state_q == c_st_idle);
  assign bus.busy       = (state_q != c_st_idle);
  assign bus.write_en   = write_en_q;
  assign bus.write_addr = write_addr_q;
  assign bus.wdata      = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_rect_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vram_rect_writer
//  Purpose  : Self-checking bench for vram_rect_writer. Expected pixel writes
//             are produced by a reference model when a command is driven and
//             compared in order as the DUT emits them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vram_rect_writer;

  localparam int ADDR_W = 20;

  logic clk;
  logic reset;

  vram_rect_writer_if #(.ADDR_W(ADDR_W)) bus ();

  vram_rect_writer #(
    .WIDTH (160),
    .HEIGHT(120),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_seen = 0;

  // Expected writes: {wdata, write_addr}
  logic [ADDR_W:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference model: plain nested loops with a real multiply for the address
  task automatic push_expect(input bit op, input int x, input int y,
                             input int w, input int h, input bit color);
    int x0, y0, x1, y1;
    if (op) begin
      x0 = 0; y0 = 0; x1 = 160; y1 = 120;
    end else begin
      x0 = x; y0 = y;
      x1 = (x + w > 160) ? 160 : x + w;
      y1 = (y + h > 120) ? 120 : y + h;
    end
    for (int r = y0; r < y1; r++)
      for (int c = x0; c < x1; c++)
        exp_q.push_back({color, 20'(r * 160 + c)});
  endtask

  // Write monitor / scoreboard consumer
  always @(negedge clk) begin
    logic [ADDR_W:0] e;
    if (!reset && bus.write_en) begin
      wr_seen++;
      check_eq("addr_range", 32'(bus.write_addr < 20'd19200), 32'd1);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 32'(bus.write_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(bus.write_addr), 32'(e[ADDR_W-1:0]));
        check_eq("wr_data", 32'(bus.wdata), 32'(e[ADDR_W]));
      end
    end
  end

  // Issue one command from IDLE and check the cycle-level envelope:
  // SETUP cycle, then exp_n consecutive writes, then idle again.
  task automatic run_cmd(input string tag, input bit op, input logic [7:0] x,
                         input logic [6:0] y, input logic [7:0] w,
                         input logic [6:0] h, input bit color, input int exp_n);
    int n;
    @(negedge clk);
    check_eq({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op    = op;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    bus.cmd_w     = w;
    bus.cmd_h     = h;
    bus.cmd_color = color;
    bus.cmd_valid = 1'b1;
    push_expect(op, int'(x), int'(y), int'(w), int'(h), color);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x     = 8'($urandom);
    bus.cmd_y     = 7'($urandom);
    bus.cmd_w     = 8'($urandom);
    bus.cmd_h     = 7'($urandom);
    bus.cmd_color = 1'($urandom);
    @(negedge clk);
    check_eq({tag, "_setup{busy,we,rdy}"},
             32'({bus.busy, bus.write_en, bus.cmd_ready}), 32'(3'b100));
    n = 0;
    @(negedge clk);
    while (bus.write_en && n < 20000) begin
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_nwrites"}, 32'(n), 32'(exp_n));
    check_eq({tag, "_end{busy,we,rdy}"},
             32'({bus.busy, bus.write_en, bus.cmd_ready}), 32'(3'b001));
  endtask

  initial begin
    int n;
    int base;
    logic [6:0] pat_we;
    logic [6:0] pat_rdy;

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_x     = 8'd0;
    bus.cmd_y     = 7'd0;
    bus.cmd_w     = 8'd0;
    bus.cmd_h     = 7'd0;
    bus.cmd_color = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_write_en",   32'(bus.write_en),   32'd0);
    check_eq("rst_write_addr", 32'(bus.write_addr), 32'd0);
    check_eq("rst_wdata",      32'(bus.wdata),      32'd0);
    check_eq("rst_busy",       32'(bus.busy),       32'd0);
    check_eq("rst_cmd_ready",  32'(bus.cmd_ready),  32'd1);
    reset = 1'b0;

    // Basic fill: 810..812, 970..972
    run_cmd("fill_small", 1'b0, 8'd10, 7'd5, 8'd3, 7'd2, 1'b1, 6);

    // Clipped at the bottom-right corner
    run_cmd("fill_clip", 1'b0, 8'd158, 7'd118, 8'd5, 7'd5, 1'b1, 4);

    // Degenerate commands
    run_cmd("degen_w0",   1'b0, 8'd10,  7'd10,  8'd0, 7'd4, 1'b1, 0);
    run_cmd("degen_h0",   1'b0, 8'd10,  7'd10,  8'd4, 7'd0, 1'b1, 0);
    run_cmd("degen_x200", 1'b0, 8'd200, 7'd10,  8'd4, 7'd4, 1'b1, 0);
    run_cmd("degen_y125", 1'b0, 8'd10,  7'd125, 8'd4, 7'd4, 1'b1, 0);

    // Full-screen clear; rectangle fields must be ignored
    run_cmd("clear", 1'b1, 8'd37, 7'd21, 8'd3, 7'd3, 1'b0, 19200);

    // Reset during row 1 of a 4x4 fill
    base = wr_seen;
    @(negedge clk);
    bus.cmd_op    = 1'b0;
    bus.cmd_x     = 8'd20;
    bus.cmd_y     = 7'd10;
    bus.cmd_w     = 8'd4;
    bus.cmd_h     = 7'd4;
    bus.cmd_color = 1'b1;
    bus.cmd_valid = 1'b1;
    push_expect(1'b0, 20, 10, 4, 4, 1'b1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (wr_seen < base + 5 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check_eq("rst_mid_reached_row1", 32'(wr_seen >= base + 5), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_write_en", 32'(bus.write_en), 32'd0);
    check_eq("rst_mid_busy",     32'(bus.busy),     32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base = wr_seen;
    @(negedge clk);
    check_eq("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (6) @(negedge clk);
    check_eq("rst_mid_no_writes", 32'(wr_seen), 32'(base));
    run_cmd("after_rst_1x1", 1'b0, 8'd0, 7'd0, 8'd1, 7'd1, 1'b1, 1);

    // Back-to-back with cmd_valid held high: writes 1, then 160, 161
    @(negedge clk);
    bus.cmd_op    = 1'b0;
    bus.cmd_x     = 8'd1;
    bus.cmd_y     = 7'd0;
    bus.cmd_w     = 8'd1;
    bus.cmd_h     = 7'd1;
    bus.cmd_color = 1'b1;
    bus.cmd_valid = 1'b1;
    push_expect(1'b0, 1, 0, 1, 1, 1'b1);
    @(posedge clk);
    #1;
    bus.cmd_x = 8'd0;
    bus.cmd_y = 7'd1;
    bus.cmd_w = 8'd2;
    bus.cmd_h = 7'd1;
    push_expect(1'b0, 0, 1, 2, 1, 1'b1);
    pat_we  = '0;
    pat_rdy = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pat_we[6-i]  = bus.write_en;
      pat_rdy[6-i] = bus.cmd_ready;
      if (i == 3) begin
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = 8'd77;
      end
    end
    check_eq("b2b_write_en_pattern",  32'(pat_we),  32'(7'b0100110));
    check_eq("b2b_cmd_ready_pattern", 32'(pat_rdy), 32'(7'b0010001));

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
